// File: rtl/spi_master_ctrl_if.sv
// Host request port and SPI pins of spi_master_ctrl.
// The master modport is the controller's view; the slave modport is the host plus the SPI device.
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int NO_OF_SLAVES = 1
) ();
    localparam int SEL_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

    logic                    start;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic [SEL_W-1:0]        slave_sel;
    logic                    cpol;
    logic                    cpha;
    logic [7:0]              baud_div;
    logic [7:0]              ct2_delay;
    logic [7:0]              t2c_delay;
    logic                    busy;
    logic                    done;
    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    sclk;
    logic [NO_OF_SLAVES-1:0] cs;
    logic                    mosi0;
    logic                    miso0;

    modport master (
        input  start, tx_data, slave_sel, cpol, cpha, baud_div, ct2_delay, t2c_delay, miso0,
        output busy, done, rx_data, sclk, cs, mosi0
    );

    modport slave (
        output start, tx_data, slave_sel, cpol, cpha, baud_div, ct2_delay, t2c_delay, miso0,
        input  busy, done, rx_data, sclk, cs, mosi0
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// Single-lane SPI master: one word per request, LSB first, any CPOL/CPHA mode,
// programmable sclk half-period and cs-to-clock / clock-to-cs delays.
module spi_master_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int NO_OF_SLAVES = 1
) (
    input  logic              i_pclk,
    input  logic              i_areset,
    spi_master_ctrl_if.master io_bus
);
    localparam int                EDGE_W    = $clog2(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                  r_state;
    logic [7:0]              r_timer;
    logic [7:0]              r_half_m1;
    logic [7:0]              r_t2c;
    logic [EDGE_W-1:0]       r_edge;
    logic                    r_cpha;
    logic [DATA_WIDTH-1:0]   r_tx;
    logic [DATA_WIDTH-1:0]   r_rx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_busy;
    logic                    r_done;
    logic [NO_OF_SLAVES-1:0] r_cs;

    logic [NO_OF_SLAVES-1:0] w_cs_sel;
    logic [7:0]              w_half_m1;
    logic                    w_leading;
    logic                    w_last;

    // Out-of-range selects decode to all ones: the transfer still runs with no device enabled.
    always_comb begin
        // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
        w_cs_sel = '1;
        for (int i = 0; i < NO_OF_SLAVES; i++) begin
            if (int'(io_bus.slave_sel) == i) w_cs_sel[i] = 1'b0;
        end
    end

    assign w_half_m1 = (io_bus.baud_div == 8'd0) ? 8'd0 : io_bus.baud_div - 8'd1;
    assign w_leading = ~r_edge[0];
    assign w_last    = (r_edge == LAST_EDGE);

    always_ff @(posedge i_pclk) begin
        if (i_areset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_half_m1  <= '0;
            r_t2c      <= '0;
            r_edge     <= '0;
            r_cpha     <= 1'b0;
            r_tx       <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= '1;
        end else begin
            // NOTE: non-blocking throughout; a later assignment in the same cycle overrides this default.
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= io_bus.cpol;
                    if (io_bus.start) begin
                        r_tx      <= io_bus.tx_data;
                        r_cpha    <= io_bus.cpha;
                        r_half_m1 <= w_half_m1;
                        r_t2c     <= io_bus.t2c_delay;
                        r_edge    <= '0;
                        r_cs      <= w_cs_sel;
                        r_busy    <= 1'b1;
                        if (!io_bus.cpha) r_mosi <= io_bus.tx_data[0];
                        if (io_bus.ct2_delay == 8'd0) begin
                            r_state <= SHIFT;
                            r_timer <= w_half_m1;
                        end else begin
                            r_state <= SETUP;
                            r_timer <= io_bus.ct2_delay - 8'd1;
                        end
                    end
                end
                SETUP: begin
                    if (r_timer == 8'd0) begin
                        r_state <= SHIFT;
                        r_timer <= r_half_m1;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                SHIFT: begin
                    if (r_timer != 8'd0) begin
                        r_timer <= r_timer - 8'd1;
                    end else begin
                        r_sclk  <= ~r_sclk;
                        r_edge  <= r_edge + 1'b1;
                        r_timer <= w_last ? r_t2c : r_half_m1;
                        if (w_last) r_state <= HOLD;
                        // Capture on leading edge for CPHA=0 and trailing edge for CPHA=1; drive on the other.
                        if (w_leading ^ r_cpha) begin
                            r_rx_shift <= {io_bus.miso0, r_rx_shift[DATA_WIDTH-1:1]};
                        end else if (r_cpha) begin
                            r_mosi <= r_tx[0];
                            r_tx   <= r_tx >> 1;
                        end else if (!w_last) begin
                            r_mosi <= r_tx[1];
                            r_tx   <= r_tx >> 1;
                        end
                    end
                end
                HOLD: begin
                    if (r_timer == 8'd0) begin
                        r_state   <= IDLE;
                        r_cs      <= '1;
                        r_rx_data <= r_rx_shift;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.busy    = r_busy;
    assign io_bus.done    = r_done;
    assign io_bus.rx_data = r_rx_data;
    assign io_bus.sclk    = r_sclk;
    assign io_bus.cs      = r_cs;
    assign io_bus.mosi0   = r_mosi;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: a protocol-level SPI slave model and a
// done-driven monitor check each transfer against expectations computed from the timing rules.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int SW = 2;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] word;
        logic [SW-1:0] sel;
        logic          cpol;
        logic          cpha;
        logic [7:0]    baud;
        logic [7:0]    ct2;
        logic [7:0]    t2c;
    } cfg_t;

    typedef struct {
        logic [DW-1:0] rx;
        int unsigned   t_start;
        int unsigned   lat;
        logic          cpol;
    } exp_t;

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] tx;
        logic          cpol;
        logic          cpha;
        bit            abort;
    } slv_t;

    logic        pclk = 1'b0;
    logic        areset;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    exp_t exp_q[$];
    slv_t slv_q[$];

    spi_master_ctrl_if #(.DATA_WIDTH(DW), .NO_OF_SLAVES(NS)) bus ();

    spi_master_ctrl #(.DATA_WIDTH(DW), .NO_OF_SLAVES(NS)) dut (
        .i_pclk   (pclk),
        .i_areset (areset),
        .io_bus   (bus)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Start-to-done latency in pclk cycles, straight from the timing rules.
    function automatic int unsigned lat_of(input cfg_t c);
        int unsigned d;
        d = (c.baud == 8'd0) ? 1 : int'(c.baud);
        return 1 + int'(c.ct2) + 2 * DW * d + int'(c.t2c) + 1;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.tx   = DW'($urandom);
        c.word = DW'($urandom);
        c.sel  = SW'($urandom_range(0, NS - 1));
        c.cpol = 1'($urandom_range(0, 1));
        c.cpha = 1'($urandom_range(0, 1));
        c.baud = 8'($urandom_range(0, 3));
        c.ct2  = 8'($urandom_range(0, 4));
        c.t2c  = 8'($urandom_range(0, 4));
        return c;
    endfunction

    // ---------------- SPI slave model ----------------
    slv_t cur;
    bit            s_active = 1'b0;
    int            s_bit = 0;
    logic [DW-1:0] s_mosi = '0;
    logic          s_prev_sclk = 1'b0;

    always @(negedge pclk) begin
        if (!s_active && bus.cs != '1) begin
            if (slv_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cs: got cs=0x%0h, expected all ones (cycle %0d)", bus.cs, cyc);
            end else begin
                cur      = slv_q.pop_front();
                s_active = 1'b1;
                s_bit    = 0;
                s_mosi   = '0;
                if (!cur.cpha) bus.miso0 = cur.word[0];
            end
        end else if (s_active && bus.cs == '1) begin
            if (!cur.abort) begin
                check("mosi_bit_count", 32'(s_bit), DW);
                check("mosi_word", 32'(s_mosi), 32'(cur.tx));
            end
            s_active  = 1'b0;
            bus.miso0 = 1'b0;
        end else if (s_active && bus.sclk != s_prev_sclk) begin
            if (!cur.cpha) begin
                if (bus.sclk != cur.cpol) begin
                    s_mosi[s_bit] = bus.mosi0;
                end else begin
                    s_bit++;
                    if (s_bit < DW) bus.miso0 = cur.word[s_bit];
                end
            end else begin
                if (bus.sclk != cur.cpol) begin
                    if (s_bit < DW) bus.miso0 = cur.word[s_bit];
                end else begin
                    if (s_bit < DW) s_mosi[s_bit] = bus.mosi0;
                    s_bit++;
                end
            end
        end else if (!s_active) begin
            bus.miso0 = 1'b0;
        end
        s_prev_sclk = bus.sclk;
    end

    // ---------------- chip-select watcher ----------------
    logic [NS-1:0] cs_prev = '1;
    logic [NS-1:0] cs_pat;
    logic [SW-1:0] cs_sel_exp = '0;

    always @(negedge pclk) begin
        if (bus.cs !== cs_prev && bus.cs !== '1) begin
            cs_pat             = '1;
            cs_pat[cs_sel_exp] = 1'b0;
            check("cs_pattern", 32'(bus.cs), 32'(cs_pat));
        end
        cs_prev = bus.cs;
    end

    // ---------------- done monitor ----------------
    int unsigned bcount = 0;
    exp_t        e;

    always @(negedge pclk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with rx=0x%0h, expected no done (cycle %0d)", bus.rx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", 32'(bus.rx_data), 32'(e.rx));
                check("latency", cyc + 1 - e.t_start, e.lat);
                check("busy_cycles", bcount, e.lat - 1);
                check("busy_low_at_done", 32'(bus.busy), 0);
                check("sclk_idle_at_done", 32'(bus.sclk), 32'(e.cpol));
                check("cs_high_at_done", 32'(bus.cs), 32'(NS'('1)));
            end
            bcount = 0;
        end else if (bus.busy === 1'b1) begin
            bcount++;
        end else begin
            bcount = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_cfg(input cfg_t c);
        bus.tx_data   = c.tx;
        bus.slave_sel = c.sel;
        bus.cpol      = c.cpol;
        bus.cpha      = c.cpha;
        bus.baud_div  = c.baud;
        bus.ct2_delay = c.ct2;
        bus.t2c_delay = c.t2c;
    endtask

    task automatic scramble(input bit hold);
        bus.tx_data   = DW'($urandom);
        bus.slave_sel = SW'($urandom);
        bus.cpol      = 1'($urandom_range(0, 1));
        bus.cpha      = 1'($urandom_range(0, 1));
        bus.baud_div  = 8'($urandom);
        bus.ct2_delay = 8'($urandom);
        bus.t2c_delay = 8'($urandom);
        if (!hold) bus.start = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge while the DUT is idle; the request is sampled on the next posedge.
    task automatic launch(input cfg_t c, input bit abort);
        exp_t x;
        slv_t s;
        drive_cfg(c);
        bus.start  = 1'b1;
        cs_sel_exp = c.sel;
        s.word = c.word; s.tx = c.tx; s.cpol = c.cpol; s.cpha = c.cpha; s.abort = abort;
        slv_q.push_back(s);
        if (!abort) begin
            x.rx = c.word; x.t_start = cyc + 1; x.lat = lat_of(c); x.cpol = c.cpol;
            exp_q.push_back(x);
        end
    endtask

    // Returns at the negedge right after the predicted done edge, so the next launch is back-to-back.
    task automatic xfer(input cfg_t c, input bit hold, input bit junk);
        int unsigned lat;
        lat = lat_of(c);
        launch(c, 1'b0);
        @(negedge pclk);
        for (int i = 0; i < int'(lat) - 1; i++) begin
            if (junk) scramble(hold);
            else if (!hold) bus.start = 1'b0;
            @(negedge pclk);
        end
        if (!hold) bus.start = 1'b0;
    endtask

    initial begin
        cfg_t c;
        areset        = 1'b1;
        bus.start     = 1'b0;
        bus.tx_data   = '0;
        bus.slave_sel = '0;
        bus.cpol      = 1'b1;
        bus.cpha      = 1'b0;
        bus.baud_div  = 8'd1;
        bus.ct2_delay = 8'd0;
        bus.t2c_delay = 8'd0;
        repeat (3) @(negedge pclk);
        check("reset_sclk", 32'(bus.sclk), 0);
        check("reset_cs", 32'(bus.cs), 32'(NS'('1)));
        check("reset_mosi", 32'(bus.mosi0), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_rx_data", 32'(bus.rx_data), 0);

        areset = 1'b0;
        repeat (2) @(negedge pclk);
        check("idle_sclk_cpol1", 32'(bus.sclk), 1);
        bus.cpol = 1'b0;
        repeat (2) @(negedge pclk);
        check("idle_sclk_cpol0", 32'(bus.sclk), 0);

        // Mode 0, A5 out, 3C back.
        c = '{tx: 8'hA5, word: 8'h3C, sel: 2'd0, cpol: 1'b0, cpha: 1'b0, baud: 8'd2, ct2: 8'd0, t2c: 8'd0};
        xfer(c, 1'b0, 1'b0);
        repeat (2) @(negedge pclk);
        // Mode 3, long setup/hold, miso low.
        c = '{tx: 8'hFF, word: 8'h00, sel: 2'd1, cpol: 1'b1, cpha: 1'b1, baud: 8'd1, ct2: 8'd3, t2c: 8'd2};
        xfer(c, 1'b0, 1'b0);
        // Modes 1 and 2 with an echoing slave.
        c = '{tx: 8'h01, word: 8'h01, sel: 2'd0, cpol: 1'b0, cpha: 1'b1, baud: 8'd3, ct2: 8'd1, t2c: 8'd1};
        xfer(c, 1'b0, 1'b0);
        c = '{tx: 8'h01, word: 8'h01, sel: 2'd3, cpol: 1'b1, cpha: 1'b0, baud: 8'd2, ct2: 8'd0, t2c: 8'd3};
        xfer(c, 1'b0, 1'b0);
        // baud_div 0 and 1 must give the same timing.
        c = '{tx: 8'h6B, word: 8'hD2, sel: 2'd1, cpol: 1'b0, cpha: 1'b0, baud: 8'd0, ct2: 8'd2, t2c: 8'd0};
        xfer(c, 1'b0, 1'b0);
        c.baud = 8'd1;
        xfer(c, 1'b0, 1'b0);

        // Reset hits on the clock edge that would produce sclk edge 6 of a mode-0 transfer.
        repeat (2) @(negedge pclk);
        c = '{tx: 8'h5A, word: 8'h96, sel: 2'd0, cpol: 1'b0, cpha: 1'b0, baud: 8'd2, ct2: 8'd0, t2c: 8'd0};
        launch(c, 1'b1);
        @(negedge pclk);
        bus.start = 1'b0;
        repeat (13) @(negedge pclk);
        areset = 1'b1;
        @(negedge pclk);
        check("abort_cs", 32'(bus.cs), 32'(NS'('1)));
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_sclk", 32'(bus.sclk), 0);
        check("abort_done", 32'(bus.done), 0);
        areset = 1'b0;
        @(negedge pclk);
        c = '{tx: 8'hC3, word: 8'h7E, sel: 2'd2, cpol: 1'b0, cpha: 1'b0, baud: 8'd2, ct2: 8'd0, t2c: 8'd0};
        xfer(c, 1'b0, 1'b0);

        // start held high: back-to-back transfers on cs[2] only.
        repeat (3) @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            c     = rand_cfg();
            c.sel = 2'd2;
            xfer(c, 1'b1, 1'b0);
        end
        bus.start = 1'b0;

        // Random transfers with inputs and start churning while busy.
        for (int i = 0; i < 20; i++) begin
            c = rand_cfg();
            xfer(c, 1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge pclk);
        repeat (4) @(negedge pclk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("slave_queue_drained", slv_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got no end of stimulus by cycle %0d, expected completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
